uart_rx_command_controller: RTL and testbench

- Consumes bytes delivered by the UART receiver (one `rx_data_valid` pulse per byte) and parses them into system commands.
- Drives register-file write/read strobes and ALU operand/function strobes.
- Sits between the UART receiver and the register file / ALU. It is the sequencer that turns the serial byte stream into datapath operations.

---
 rtl/uart_sys_pkg.sv | 34 +++
 rtl/frame_timeout_counter.sv | 41 ++++
 rtl/uart_rx_command_controller.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_command_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART command path: command byte codes,
// controller state encoding and the fixed ALU operand register addresses.
package uart_sys_pkg;

   // First byte of a frame selects the command
   localparam logic [7:0] CMD_REG_WR  = 8'hAA;
   localparam logic [7:0] CMD_REG_RD  = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   // Controller state encoding; 3'd7 is unused and recovers to idle
   localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
   localparam logic [2:0] ST_WR_ADDR_ENC  = 3'd1;
   localparam logic [2:0] ST_WR_DATA_ENC  = 3'd2;
   localparam logic [2:0] ST_RD_ADDR_ENC  = 3'd3;
   localparam logic [2:0] ST_ALU_OPA_ENC  = 3'd4;
   localparam logic [2:0] ST_ALU_OPB_ENC  = 3'd5;
   localparam logic [2:0] ST_ALU_FUNC_ENC = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE     = ST_IDLE_ENC,
      ST_WR_ADDR  = ST_WR_ADDR_ENC,
      ST_WR_DATA  = ST_WR_DATA_ENC,
      ST_RD_ADDR  = ST_RD_ADDR_ENC,
      ST_ALU_OPA  = ST_ALU_OPA_ENC,
      ST_ALU_OPB  = ST_ALU_OPB_ENC,
      ST_ALU_FUNC = ST_ALU_FUNC_ENC
   } state_e;

   // Register-file slots the ALU reads its operands from
   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog for a partially received frame. Down-counter that is
// reloaded by every received byte (clear) and while no frame is open
// (enable low); expire is a combinational pulse in the cycle the count has
// run out with no byte arriving, so a byte on that same cycle always wins.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Terminal-count compare and reload/decrement selection
   always_comb begin
      expire = enable && !clear && (cnt_q == '0);
      cnt_d  = cnt_q;
      if (clear || !enable || expire) begin
         cnt_d = LOAD;
      end else begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_command_controller.sv
// Byte-stream command parser between the UART receiver and the register
// file / ALU. Every output is registered; strobes and cmd_error are single
// cycle pulses one clock after the byte that completes a step.
// Build option: define UART_RX_CMD_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES clocks without a byte (the parameter exists only
// in that build).
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_WR_ADDR  | register write, next byte is the address
// ST_WR_DATA  | register write, next byte is the data (write strobe)
// ST_RD_ADDR  | register read, next byte is the address (read strobe)
// ST_ALU_OPA  | ALU op, next byte is operand A (written to OPA_ADDR)
// ST_ALU_OPB  | ALU op, next byte is operand B (written to OPB_ADDR)
// ST_ALU_FUNC | next byte is the ALU function (execute strobe)
module uart_rx_command_controller
   import uart_sys_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUNC_WIDTH = 4
`ifdef UART_RX_CMD_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_data_valid,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic                  alu_enable,
   output logic [FUNC_WIDTH-1:0] alu_function,
   output logic                  busy,
   output logic                  cmd_error
);

   state_e                  state_q, state_d;
   logic                    reg_wr_en_q, reg_wr_en_d;
   logic                    reg_rd_en_q, reg_rd_en_d;
   logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
   logic [DATA_WIDTH-1:0]   reg_wr_data_q, reg_wr_data_d;
   logic                    alu_enable_q, alu_enable_d;
   logic [FUNC_WIDTH-1:0]   alu_function_q, alu_function_d;
   logic                    busy_q, busy_d;
   logic                    cmd_error_q, cmd_error_d;
   logic                    timeout_expire;

`ifdef UART_RX_CMD_TIMEOUT_EN
   frame_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (rx_data_valid),
      .enable (state_q != ST_IDLE),
      .expire (timeout_expire)
   );
`else
   assign timeout_expire = 1'b0;
`endif

   // Next-state and next-output decode; advances only on a valid byte
   always_comb begin
      state_d        = state_q;
      reg_addr_d     = reg_addr_q;
      reg_wr_data_d  = reg_wr_data_q;
      alu_function_d = alu_function_q;
      reg_wr_en_d    = 1'b0;
      reg_rd_en_d    = 1'b0;
      alu_enable_d   = 1'b0;
      cmd_error_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_data_valid) begin
               case (rx_data)
                  DATA_WIDTH'(CMD_REG_WR):  state_d = ST_WR_ADDR;
                  DATA_WIDTH'(CMD_REG_RD):  state_d = ST_RD_ADDR;
                  DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_ALU_OPA;
                  DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FUNC;
                  default:                  cmd_error_d = 1'b1;
               endcase
            end
         end
         ST_WR_ADDR: begin
            if (rx_data_valid) begin
               reg_addr_d = rx_data[ADDR_WIDTH-1:0];
               state_d    = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (rx_data_valid) begin
               reg_wr_data_d = rx_data;
               reg_wr_en_d   = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_RD_ADDR: begin
            if (rx_data_valid) begin
               reg_addr_d  = rx_data[ADDR_WIDTH-1:0];
               reg_rd_en_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_ALU_OPA: begin
            if (rx_data_valid) begin
               reg_addr_d    = ADDR_WIDTH'(OPA_ADDR);
               reg_wr_data_d = rx_data;
               reg_wr_en_d   = 1'b1;
               state_d       = ST_ALU_OPB;
            end
         end
         ST_ALU_OPB: begin
            if (rx_data_valid) begin
               reg_addr_d    = ADDR_WIDTH'(OPB_ADDR);
               reg_wr_data_d = rx_data;
               reg_wr_en_d   = 1'b1;
               state_d       = ST_ALU_FUNC;
            end
         end
         ST_ALU_FUNC: begin
            if (rx_data_valid) begin
               alu_function_d = rx_data[FUNC_WIDTH-1:0];
               alu_enable_d   = 1'b1;
               state_d        = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Expiry is never raised alongside a valid byte, so no strobe is lost
      if (timeout_expire) begin
         state_d     = ST_IDLE;
         cmd_error_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         reg_wr_en_q    <= 1'b0;
         reg_rd_en_q    <= 1'b0;
         reg_addr_q     <= '0;
         reg_wr_data_q  <= '0;
         alu_enable_q   <= 1'b0;
         alu_function_q <= '0;
         busy_q         <= 1'b0;
         cmd_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         reg_wr_en_q    <= reg_wr_en_d;
         reg_rd_en_q    <= reg_rd_en_d;
         reg_addr_q     <= reg_addr_d;
         reg_wr_data_q  <= reg_wr_data_d;
         alu_enable_q   <= alu_enable_d;
         alu_function_q <= alu_function_d;
         busy_q         <= busy_d;
         cmd_error_q    <= cmd_error_d;
      end
   end

   assign reg_wr_en    = reg_wr_en_q;
   assign reg_rd_en    = reg_rd_en_q;
   assign reg_addr     = reg_addr_q;
   assign reg_wr_data  = reg_wr_data_q;
   assign alu_enable   = alu_enable_q;
   assign alu_function = alu_function_q;
   assign busy         = busy_q;
   assign cmd_error    = cmd_error_q;

endmodule

// File: tb/tb_uart_rx_command_controller.sv
// Self-checking bench for uart_rx_command_controller. A frame-level model
// (byte queue per open frame) predicts every output each cycle; directed
// frames also carry hand-computed literal expectations.
module tb_uart_rx_command_controller;

`ifdef UART_RX_CMD_TIMEOUT_EN
   localparam int TO = 16;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_data_valid = 1'b0;
   logic       reg_wr_en, reg_rd_en, alu_enable, busy, cmd_error;
   logic [3:0] reg_addr, alu_function;
   logic [7:0] reg_wr_data;

   int checks = 0;
   int errors = 0;
   int n_strobes = 0;
   int base;

   // model state
   logic       m_wr, m_rd, m_alu, m_err, m_busy;
   logic [3:0] m_addr, m_func;
   logic [7:0] m_wdata;
   logic [7:0] frame[$];
   int         gap;

   uart_rx_command_controller #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4),
      .FUNC_WIDTH (4)
`ifdef UART_RX_CMD_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TO)
`endif
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .reg_wr_en     (reg_wr_en),
      .reg_rd_en     (reg_rd_en),
      .reg_addr      (reg_addr),
      .reg_wr_data   (reg_wr_data),
      .alu_enable    (alu_enable),
      .alu_function  (alu_function),
      .busy          (busy),
      .cmd_error     (cmd_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data_valid = 1'b1;
      rx_data       = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_data_valid = 1'b0;
      rx_data       = 8'h00;
      repeat (n) @(negedge clk);
   endtask

   // frame-level model: collects the bytes of the open frame
   initial begin
      m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0; m_busy = 0;
      m_addr = 0; m_func = 0; m_wdata = 0; gap = 0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0; m_busy = 0;
            m_addr = 0; m_func = 0; m_wdata = 0; gap = 0;
            frame.delete();
         end else begin
            m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0;
            if (rx_data_valid) begin
               gap = 0;
               if (frame.size() == 0) begin
                  if (rx_data == 8'hAA || rx_data == 8'hBB || rx_data == 8'hCC || rx_data == 8'hDD)
                     frame.push_back(rx_data);
                  else
                     m_err = 1;
               end else begin
                  frame.push_back(rx_data);
                  case (frame[0])
                     8'hAA: begin
                        if (frame.size() == 2) m_addr = 4'(int'(rx_data) % 16);
                        else begin m_wdata = rx_data; m_wr = 1; frame.delete(); end
                     end
                     8'hBB: begin
                        m_addr = 4'(int'(rx_data) % 16); m_rd = 1; frame.delete();
                     end
                     8'hCC: begin
                        if (frame.size() == 2) begin m_addr = 0; m_wdata = rx_data; m_wr = 1; end
                        else if (frame.size() == 3) begin m_addr = 1; m_wdata = rx_data; m_wr = 1; end
                        else begin m_func = 4'(int'(rx_data) % 16); m_alu = 1; frame.delete(); end
                     end
                     default: begin
                        m_func = 4'(int'(rx_data) % 16); m_alu = 1; frame.delete();
                     end
                  endcase
               end
            end else if (frame.size() != 0) begin
               gap++;
`ifdef UART_RX_CMD_TIMEOUT_EN
               if (gap == TO) begin
                  m_err = 1; frame.delete(); gap = 0;
               end
`endif
            end
            m_busy = (frame.size() != 0);
         end
      end
   end

   // per-cycle compare against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("m_wr_en", reg_wr_en, m_wr);
            chk("m_rd_en", reg_rd_en, m_rd);
            chk("m_alu_en", alu_enable, m_alu);
            chk("m_cmd_error", cmd_error, m_err);
            chk("m_busy", busy, m_busy);
            chk("m_reg_addr", reg_addr, m_addr);
            chk("m_wr_data", reg_wr_data, m_wdata);
            chk("m_alu_func", alu_function, m_func);
            n_strobes += int'(reg_wr_en) + int'(reg_rd_en) + int'(alu_enable);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_wr_en", reg_wr_en, 0);
      chk("rst_rd_en", reg_rd_en, 0);
      chk("rst_alu_en", alu_enable, 0);
      chk("rst_err", cmd_error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_wdata", reg_wr_data, 0);
      chk("rst_func", alu_function, 0);
      reset = 1'b1;
      @(negedge clk);

      // register write with gaps between bytes
      send(8'hAA); chk("wr_busy1", busy, 1);
      idle(2);
      send(8'h05); chk("wr_busy2", busy, 1); chk("wr_addr", reg_addr, 4'h5);
      idle(1);
      send(8'h3C); chk("wr_en", reg_wr_en, 1); chk("wr_addr2", reg_addr, 4'h5);
      chk("wr_data", reg_wr_data, 8'h3C); chk("wr_busy3", busy, 0);
      idle(1); chk("wr_en_off", reg_wr_en, 0); chk("wr_data_hold", reg_wr_data, 8'h3C);

      // register read, upper address bits dropped
      send(8'hBB); send(8'h1F);
      chk("rd_en", reg_rd_en, 1); chk("rd_addr", reg_addr, 4'hF); chk("rd_no_wr", reg_wr_en, 0);
      idle(2);

      // ALU with operands: exactly three strobes
      base = n_strobes;
      send(8'hCC);
      send(8'h12); chk("opa_wr", reg_wr_en, 1); chk("opa_addr", reg_addr, 0); chk("opa_data", reg_wr_data, 8'h12);
      idle(1);
      send(8'h34); chk("opb_wr", reg_wr_en, 1); chk("opb_addr", reg_addr, 1); chk("opb_data", reg_wr_data, 8'h34);
      send(8'h02); chk("alu_en", alu_enable, 1); chk("alu_func", alu_function, 2); chk("alu_no_wr", reg_wr_en, 0);
      idle(2);
      chk("alu_strobe_count", n_strobes - base, 3);

      // unknown command, then ALU without operands
      send(8'h55); chk("bad_err", cmd_error, 1); chk("bad_busy", busy, 0);
      send(8'hDD); chk("nop_err_off", cmd_error, 0); chk("nop_busy", busy, 1);
      send(8'h07); chk("nop_alu_en", alu_enable, 1); chk("nop_func", alu_function, 7);
      idle(1); chk("nop_alu_off", alu_enable, 0); chk("nop_func_hold", alu_function, 7);

      // command code inside a frame is payload
      send(8'hAA); send(8'hAA); chk("pay_addr", reg_addr, 4'hA);
      send(8'hAA); chk("pay_wr", reg_wr_en, 1); chk("pay_data", reg_wr_data, 8'hAA); chk("pay_busy", busy, 0);

      // back-to-back frames at one byte per cycle
      send(8'hDD); send(8'h19); chk("b2b_alu", alu_enable, 1); chk("b2b_func", alu_function, 9);
      send(8'hBB); chk("b2b_alu_off", alu_enable, 0); chk("b2b_busy", busy, 1); chk("b2b_err", cmd_error, 0);
      send(8'h23); chk("b2b_rd", reg_rd_en, 1); chk("b2b_addr", reg_addr, 3);
      idle(1);

      // reset mid-frame discards the partial frame
      send(8'hAA); send(8'h05);
      rx_data_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("mrst_addr", reg_addr, 0); chk("mrst_busy", busy, 0); chk("mrst_wdata", reg_wr_data, 0);
      chk("mrst_func", alu_function, 0); chk("mrst_wr", reg_wr_en, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send(8'h3C); chk("mrst_err", cmd_error, 1); chk("mrst_no_wr", reg_wr_en, 0); chk("mrst_busy2", busy, 0);
      idle(2);

`ifdef UART_RX_CMD_TIMEOUT_EN
      // abandoned frame times out after TO idle cycles
      send(8'hAA); idle(TO - 1);
      chk("to_pre_err", cmd_error, 0); chk("to_pre_busy", busy, 1);
      idle(1);
      chk("to_err", cmd_error, 1); chk("to_busy", busy, 0); chk("to_no_wr", reg_wr_en, 0);
      idle(2);
      // byte on the expiry cycle wins
      send(8'hAA); idle(TO - 1);
      send(8'h05); chk("tow_err", cmd_error, 0); chk("tow_busy", busy, 1); chk("tow_addr", reg_addr, 5);
      send(8'h3C); chk("tow_wr", reg_wr_en, 1); chk("tow_data", reg_wr_data, 8'h3C);
      idle(2);
`endif

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
